// File: rtl/adc_spi_tx.sv
// ADS5292 serial-port transmitter: shifts 24-bit {addr, data} words MSB-first on sen_n/sclk/sdata
// and sequences the register unit for auto configuration. Option: `ADC_SPI_SRESET_EN (software-reset frame first).
module adc_spi_tx #(
   parameter int CLK_DIV = 4
) (
   input  logic        clk,
   input  logic        rstb,
   input  logic [23:0] reg_in,
   input  logic        end_auto,
   input  logic        start,
   input  logic        auto_start,
   output logic        init_reg,
   output logic        incr_reg,
   output logic        auto_run,
   output logic        sclk,
   output logic        sdata,
   output logic        sen_n,
   output logic        busy,
   output logic        frame_done,
   output logic        auto_done
);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT_HI, SHIFT_LO, GAP} frame_state_t;
   typedef enum logic [2:0] {A_IDLE, A_INIT, A_LATCH, A_SEND, A_INCR} auto_state_t;

   localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);

   frame_state_t f_state, f_state_nx;
   auto_state_t  a_state, a_state_nx;

   logic [7:0]  div_cnt, div_cnt_nx;
   logic [4:0]  bit_cnt, bit_cnt_nx;
   logic        gap_half, gap_half_nx;
   logic [23:0] shadow, shadow_nx;
   logic        end_latched, end_latched_nx;
   logic        sclk_nx, sdata_nx, sen_n_nx;
   logic        auto_done_nx;
   logic        launch;
   logic [23:0] launch_word;
   logic        frame_end;
`ifdef ADC_SPI_SRESET_EN
   logic        srst_phase, srst_phase_nx;
`endif

   // Last cycle of the second GAP half: the frame FSM returns to IDLE on this edge.
   assign frame_end = (f_state == GAP) && (div_cnt == 8'd0) && gap_half;

   // Auto sequencer and trigger arbitration (auto_start has priority over start).
   always_comb begin
      a_state_nx     = a_state;
      end_latched_nx = end_latched;
      auto_done_nx   = 1'b0;
      launch         = 1'b0;
      launch_word    = reg_in;
`ifdef ADC_SPI_SRESET_EN
      srst_phase_nx  = srst_phase;
`endif
      case (a_state)
         A_IDLE: begin
            if ((f_state == IDLE) && auto_start) begin
`ifdef ADC_SPI_SRESET_EN
               a_state_nx    = A_SEND;
               launch        = 1'b1;
               launch_word   = 24'h00_0001;
               srst_phase_nx = 1'b1;
`else
               a_state_nx    = A_INIT;
`endif
            end else if ((f_state == IDLE) && start) begin
               launch = 1'b1;
            end
         end
         A_INIT: begin
            a_state_nx = A_LATCH;
         end
         A_LATCH: begin
            launch         = 1'b1;
            end_latched_nx = end_auto;
            a_state_nx     = A_SEND;
         end
         A_SEND: begin
            if (frame_end) begin
`ifdef ADC_SPI_SRESET_EN
               if (srst_phase) begin
                  srst_phase_nx = 1'b0;
                  a_state_nx    = A_INIT;
               end else
`endif
               if (end_latched) begin
                  a_state_nx   = A_IDLE;
                  auto_done_nx = 1'b1;
               end else begin
                  a_state_nx   = A_INCR;
               end
            end
         end
         A_INCR: begin
            a_state_nx = A_LATCH;
         end
         default: begin
            a_state_nx = A_IDLE;
         end
      endcase
   end

   // Frame FSM: outputs are registered, so each state's pin values are set on entry.
   always_comb begin
      f_state_nx  = f_state;
      div_cnt_nx  = div_cnt;
      bit_cnt_nx  = bit_cnt;
      gap_half_nx = gap_half;
      shadow_nx   = shadow;
      sclk_nx     = sclk;
      sdata_nx    = sdata;
      sen_n_nx    = sen_n;
      case (f_state)
         IDLE: begin
            if (launch) begin
               f_state_nx = SETUP;
               shadow_nx  = launch_word;
               div_cnt_nx = DIV_LOAD;
               bit_cnt_nx = 5'd23;
               sen_n_nx   = 1'b0;
               sclk_nx    = 1'b0;
               sdata_nx   = launch_word[23];
            end
         end
         SETUP: begin
            if (div_cnt == 8'd0) begin
               f_state_nx = SHIFT_HI;
               div_cnt_nx = DIV_LOAD;
               sclk_nx    = 1'b1;
            end else begin
               div_cnt_nx = div_cnt - 8'd1;
            end
         end
         SHIFT_HI: begin
            if (div_cnt == 8'd0) begin
               f_state_nx = SHIFT_LO;
               div_cnt_nx = DIV_LOAD;
               sclk_nx    = 1'b0;
               // Bit 0 stays on sdata through its falling edge; earlier bits advance here.
               if (bit_cnt != 5'd0) begin
                  shadow_nx = {shadow[22:0], 1'b0};
                  sdata_nx  = shadow[22];
               end
            end else begin
               div_cnt_nx = div_cnt - 8'd1;
            end
         end
         SHIFT_LO: begin
            if (div_cnt == 8'd0) begin
               div_cnt_nx = DIV_LOAD;
               if (bit_cnt == 5'd0) begin
                  f_state_nx  = GAP;
                  gap_half_nx = 1'b0;
                  sen_n_nx    = 1'b1;
                  sdata_nx    = 1'b0;
               end else begin
                  f_state_nx = SHIFT_HI;
                  bit_cnt_nx = bit_cnt - 5'd1;
                  sclk_nx    = 1'b1;
               end
            end else begin
               div_cnt_nx = div_cnt - 8'd1;
            end
         end
         GAP: begin
            // Two divider periods; the half flag keeps the divider at 8 bits for any CLK_DIV.
            if (div_cnt == 8'd0) begin
               div_cnt_nx = DIV_LOAD;
               if (gap_half) begin
                  f_state_nx = IDLE;
               end else begin
                  gap_half_nx = 1'b1;
               end
            end else begin
               div_cnt_nx = div_cnt - 8'd1;
            end
         end
         default: begin
            f_state_nx = IDLE;
            sen_n_nx   = 1'b1;
            sclk_nx    = 1'b0;
            sdata_nx   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         f_state     <= IDLE;
         a_state     <= A_IDLE;
         div_cnt     <= 8'd0;
         bit_cnt     <= 5'd0;
         gap_half    <= 1'b0;
         shadow      <= 24'd0;
         end_latched <= 1'b0;
         sclk        <= 1'b0;
         sdata       <= 1'b0;
         sen_n       <= 1'b1;
         busy        <= 1'b0;
         auto_run    <= 1'b0;
         init_reg    <= 1'b0;
         incr_reg    <= 1'b0;
         frame_done  <= 1'b0;
         auto_done   <= 1'b0;
      end else begin
         f_state     <= f_state_nx;
         a_state     <= a_state_nx;
         div_cnt     <= div_cnt_nx;
         bit_cnt     <= bit_cnt_nx;
         gap_half    <= gap_half_nx;
         shadow      <= shadow_nx;
         end_latched <= end_latched_nx;
         sclk        <= sclk_nx;
         sdata       <= sdata_nx;
         sen_n       <= sen_n_nx;
         busy        <= (f_state_nx != IDLE) || (a_state_nx != A_IDLE);
         auto_run    <= (a_state_nx != A_IDLE);
         init_reg    <= (a_state_nx == A_INIT);
         incr_reg    <= (a_state_nx == A_INCR);
         frame_done  <= frame_end;
         auto_done   <= auto_done_nx;
      end
   end

`ifdef ADC_SPI_SRESET_EN
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         srst_phase <= 1'b0;
      end else begin
         srst_phase <= srst_phase_nx;
      end
   end
`endif

endmodule

// File: tb/tb_adc_spi_tx.sv
// Directed bench for adc_spi_tx: one instance at CLK_DIV=4, one at CLK_DIV=1, with a register-unit model.
module tb_adc_spi_tx;

   localparam int N   = 2;
   localparam int LOG = 64;
`ifdef ADC_SPI_SRESET_EN
   localparam int EXP_INIT_REL = 1 + 51 * 4;
   localparam int EXP_LOW_REL  = 1;
`else
   localparam int EXP_INIT_REL = 1;
   localparam int EXP_LOW_REL  = 3;
`endif

   logic        clk = 1'b0;
   logic        rstb;
   int          cyc = 0;

   logic [23:0] man_word [N];
   logic        model_en [N];
   int          cnt [N];
   logic [23:0] reg_in [N];
   logic        end_auto [N];
   logic        start [N];
   logic        auto_start [N];
   logic        init_reg [N];
   logic        incr_reg [N];
   logic        auto_run [N];
   logic        sclk [N];
   logic        sdata [N];
   logic        sen_n [N];
   logic        busy [N];
   logic        frame_done [N];
   logic        auto_done [N];

   // monitor state
   logic        prev_sclk [N];
   logic        prev_sen [N];
   logic [23:0] cur_word [N];
   int          cur_bits [N];
   int          cur_low [N];
   int          cur_start [N];
   int          cur_rise [N];
   logic [23:0] word_log [N][LOG];
   int          bits_log [N][LOG];
   int          low_log [N][LOG];
   int          start_log [N][LOG];
   int          rise_log [N][LOG];
   int          frame_cnt [N] = '{0, 0};
   int          done_cnt [N]  = '{0, 0};
   int          done_cyc [N]  = '{0, 0};
   int          init_cnt [N]  = '{0, 0};
   int          init_cyc [N]  = '{0, 0};
   int          incr_cnt [N]  = '{0, 0};
   int          adone_cnt [N] = '{0, 0};

   logic [23:0] exp_q [$];
   int          n_checks = 0;
   int          n_pass = 0;

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   adc_spi_tx #(.CLK_DIV(4)) dut4 (
      .clk(clk), .rstb(rstb), .reg_in(reg_in[0]), .end_auto(end_auto[0]),
      .start(start[0]), .auto_start(auto_start[0]),
      .init_reg(init_reg[0]), .incr_reg(incr_reg[0]), .auto_run(auto_run[0]),
      .sclk(sclk[0]), .sdata(sdata[0]), .sen_n(sen_n[0]), .busy(busy[0]),
      .frame_done(frame_done[0]), .auto_done(auto_done[0])
   );

   adc_spi_tx #(.CLK_DIV(1)) dut1 (
      .clk(clk), .rstb(rstb), .reg_in(reg_in[1]), .end_auto(end_auto[1]),
      .start(start[1]), .auto_start(auto_start[1]),
      .init_reg(init_reg[1]), .incr_reg(incr_reg[1]), .auto_run(auto_run[1]),
      .sclk(sclk[1]), .sdata(sdata[1]), .sen_n(sen_n[1]), .busy(busy[1]),
      .frame_done(frame_done[1]), .auto_done(auto_done[1])
   );

   function automatic logic [23:0] model_word(input int c);
      case (c)
         1:       return 24'h26_AA80;
         2:       return 24'h27_5540;
         3:       return 24'h45_0001;
         default: return 24'h00_0000;
      endcase
   endfunction

   // register-unit model: counter reset by init_reg, advanced by incr_reg
   always @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (init_reg[i]) cnt[i] <= 1;
         else if (incr_reg[i]) cnt[i] <= cnt[i] + 1;
      end
   end

   always_comb begin
      for (int i = 0; i < N; i++) begin
         reg_in[i]   = model_en[i] ? model_word(cnt[i]) : man_word[i];
         end_auto[i] = model_en[i] && (cnt[i] == 3);
      end
   end

   // pin monitor, sampled on the falling clock edge
   always @(negedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (!rstb) begin
            prev_sclk[i] = 1'b0;
            prev_sen[i]  = 1'b1;
            cur_bits[i]  = 0;
         end else begin
            if (prev_sen[i] && !sen_n[i]) begin
               cur_start[i] = cyc;
               cur_low[i]   = 0;
               cur_bits[i]  = 0;
               cur_word[i]  = 24'd0;
               cur_rise[i]  = -1;
            end
            if (!sen_n[i]) cur_low[i]++;
            if (sclk[i] && !prev_sclk[i]) begin
               if (cur_bits[i] == 0) cur_rise[i] = cyc;
               cur_word[i] = {cur_word[i][22:0], sdata[i]};
               cur_bits[i]++;
            end
            if (sen_n[i] && !prev_sen[i] && frame_cnt[i] < LOG) begin
               word_log[i][frame_cnt[i]]  = cur_word[i];
               bits_log[i][frame_cnt[i]]  = cur_bits[i];
               low_log[i][frame_cnt[i]]   = cur_low[i];
               start_log[i][frame_cnt[i]] = cur_start[i];
               rise_log[i][frame_cnt[i]]  = cur_rise[i];
               frame_cnt[i]++;
            end
            if (frame_done[i]) begin
               done_cyc[i] = cyc;
               done_cnt[i]++;
            end
            if (init_reg[i]) begin
               init_cyc[i] = cyc;
               init_cnt[i]++;
            end
            if (incr_reg[i]) incr_cnt[i]++;
            if (auto_done[i]) adone_cnt[i]++;
            prev_sclk[i] = sclk[i];
            prev_sen[i]  = sen_n[i];
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // one manual frame; the start is asserted in the current cycle
   task automatic run_manual(input int i, input logic [23:0] w, input int d, input bit toggle,
                             input string tag);
      int s, n0, d0, t;
      n0 = frame_cnt[i];
      d0 = done_cnt[i];
      check({tag, "_idle"}, 32'(busy[i]), 0);
      man_word[i] = w;
      start[i]    = 1'b1;
      s           = cyc;
      tick();
      start[i] = 1'b0;
      t = 0;
      while (done_cnt[i] == d0 && t < 60 * d + 20) begin
         if (toggle) man_word[i] = ~man_word[i];
         tick();
         t++;
      end
      check({tag, "_done_seen"}, done_cnt[i] - d0, 1);
      check({tag, "_frames"}, frame_cnt[i] - n0, 1);
      check({tag, "_word"}, 32'(word_log[i][n0]), 32'(w));
      check({tag, "_bits"}, bits_log[i][n0], 24);
      check({tag, "_sen_low"}, low_log[i][n0], 49 * d);
      check({tag, "_sen_fall"}, start_log[i][n0] - s, 1);
      check({tag, "_first_rise"}, rise_log[i][n0] - s, 1 + d);
      check({tag, "_done_cyc"}, done_cyc[i] - s, 1 + 51 * d);
      check({tag, "_frame_len"}, done_cyc[i] - start_log[i][n0], 51 * d);
      check({tag, "_busy_end"}, 32'(busy[i]), 0);
   endtask

   // auto run on the CLK_DIV=4 instance, scoreboarded against the expected word list
   task automatic run_auto(input logic with_start, input string tag);
      int s, n0, i0, c0, a0, t, k;
      n0 = frame_cnt[0];
      i0 = init_cnt[0];
      c0 = incr_cnt[0];
      a0 = adone_cnt[0];
      model_en[0]   = 1'b1;
      man_word[0]   = 24'hAB_CDEF;
      auto_start[0] = 1'b1;
      start[0]      = with_start;
      s             = cyc;
      tick();
      auto_start[0] = 1'b0;
      start[0]      = 1'b0;
      repeat (30) tick();
      check({tag, "_busy_mid"}, 32'(busy[0]), 1);
      auto_start[0] = 1'b1;
      start[0]      = 1'b1;
      tick();
      auto_start[0] = 1'b0;
      start[0]      = 1'b0;
      t = 0;
      while (adone_cnt[0] == a0 && t < 1500) begin
         tick();
         t++;
      end
      check({tag, "_auto_done"}, adone_cnt[0] - a0, 1);
      check({tag, "_busy_end"}, 32'(busy[0]), 0);
      check({tag, "_auto_run_end"}, 32'(auto_run[0]), 0);
`ifdef ADC_SPI_SRESET_EN
      exp_q.push_back(24'h00_0001);
`endif
      exp_q.push_back(24'h26_AA80);
      exp_q.push_back(24'h27_5540);
      exp_q.push_back(24'h45_0001);
      k = 0;
      while (exp_q.size() > 0) begin
         check({tag, "_word"}, 32'(word_log[0][n0 + k]), 32'(exp_q.pop_front()));
         check({tag, "_bits"}, bits_log[0][n0 + k], 24);
         k++;
      end
      check({tag, "_frames"}, frame_cnt[0] - n0, k);
      check({tag, "_init_pulses"}, init_cnt[0] - i0, 1);
      check({tag, "_incr_pulses"}, incr_cnt[0] - c0, 2);
      check({tag, "_init_cyc"}, init_cyc[0] - s, EXP_INIT_REL);
      check({tag, "_sen_fall"}, start_log[0][n0] - s, EXP_LOW_REL);
      model_en[0] = 1'b0;
   endtask

   initial begin
      int n0, d0, s, t;
      rstb = 1'b0;
      for (int i = 0; i < N; i++) begin
         start[i]      = 1'b0;
         auto_start[i] = 1'b0;
         man_word[i]   = 24'd0;
         model_en[i]   = 1'b0;
      end
      repeat (3) tick();
      check("reset_pins_div4", {sclk[0], sdata[0], sen_n[0], busy[0], auto_run[0], init_reg[0],
                                incr_reg[0], frame_done[0], auto_done[0]}, 32'b001000000);
      check("reset_pins_div1", {sclk[1], sdata[1], sen_n[1], busy[1], auto_run[1], init_reg[1],
                                incr_reg[1], frame_done[1], auto_done[1]}, 32'b001000000);
      rstb = 1'b1;
      repeat (2) tick();

      run_manual(0, 24'h26_AA80, 4, 1'b0, "m4");
      run_manual(0, 24'h27_5540, 4, 1'b0, "m4_b2b");
      run_manual(1, 24'h45_0001, 1, 1'b1, "m1_toggle");

      // start while a frame is in flight must be dropped
      repeat (3) tick();
      n0 = frame_cnt[0];
      d0 = done_cnt[0];
      man_word[0] = 24'h3C_0F55;
      start[0]    = 1'b1;
      tick();
      start[0] = 1'b0;
      repeat (40) tick();
      check("busy_start_busy", 32'(busy[0]), 1);
      man_word[0] = 24'h0F_0F0F;
      start[0]    = 1'b1;
      tick();
      start[0] = 1'b0;
      t = 0;
      while (done_cnt[0] == d0 && t < 400) begin
         tick();
         t++;
      end
      repeat (300) tick();
      check("busy_start_frames", frame_cnt[0] - n0, 1);
      check("busy_start_word", 32'(word_log[0][n0]), 32'h3C_0F55);

      // asynchronous reset while sclk is high for bit 12
      man_word[0] = 24'h12_3456;
      start[0]    = 1'b1;
      s           = cyc;
      tick();
      start[0] = 1'b0;
      while (cyc - s < 94) tick();
      check("rst_pre_sclk", 32'(sclk[0]), 1);
      check("rst_pre_bits", cur_bits[0], 12);
      #1 rstb = 1'b0;
      #1;
      check("rst_sclk", 32'(sclk[0]), 0);
      check("rst_sen_n", 32'(sen_n[0]), 1);
      check("rst_busy", 32'(busy[0]), 0);
      repeat (2) tick();
      rstb = 1'b1;
      repeat (2) tick();
      run_manual(0, 24'h5A_3C96, 4, 1'b0, "post_rst");

      repeat (3) tick();
      run_auto(1'b0, "auto");
      repeat (5) tick();
      run_auto(1'b1, "auto_and_start");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
